// File: rtl/golden_nonce_queue.sv
// Turns each change of the core's golden_nonce into a {nonce, work_id} event and queues it.
// Latency is 2 cycles from find to head. The consumer stalls via out_ready; results arriving while full are dropped and counted.
module golden_nonce_queue #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           golden_nonce,
  input  logic [31:0]           nonce,
  input  logic [7:0]            work_id,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_nonce,
  output logic [7:0]            out_work_id,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            overflow_cnt,
  output logic                  exhausted
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [31:0]           gn_q, gn_prev_q;
  logic [7:0]            wid_q;
  logic                  nn_msb_q, nn_msb_prev_q;
  logic                  v_q, armed_q;

  logic [39:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            ovf_q, ovf_d;
  logic                  exh_q, exh_d;
  logic [39:0]           head_q, head_d;

  logic push, pop, full, do_push, drop, wrap;

  // Only the sign bit of the running nonce matters for wrap detection.
  logic nonce_unused;
  assign nonce_unused = ^nonce[30:0];

  always_comb begin
    push     = armed_q & (gn_q != gn_prev_q) & ~flush;
    pop      = out_valid & out_ready;
    full     = (count_q == FULL_CNT);
    do_push  = push & (~full | pop);
    drop     = push & full & ~pop;
    wrap     = armed_q & nn_msb_prev_q & ~nn_msb_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    exh_d    = exh_q;
    ovf_d    = ovf_q;
    head_d   = '0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      exh_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (wrap) exh_d = 1'b1;
    end

    if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;

    // The new head may be the entry being written this very cycle.
    if (count_d != '0) begin
      if (do_push && wr_ptr_q == rd_ptr_d) head_d = {gn_q, wid_q};
      else                                 head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gn_q          <= '0;
      gn_prev_q     <= '0;
      wid_q         <= '0;
      nn_msb_q      <= 1'b0;
      nn_msb_prev_q <= 1'b0;
      v_q           <= 1'b0;
      armed_q       <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ovf_q         <= '0;
      exh_q         <= 1'b0;
      head_q        <= '0;
    end else begin
      gn_q          <= golden_nonce;
      gn_prev_q     <= gn_q;
      wid_q         <= work_id;
      nn_msb_q      <= nonce[31];
      nn_msb_prev_q <= nn_msb_q;
      v_q           <= 1'b1;
      armed_q       <= v_q;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      exh_q         <= exh_d;
      head_q        <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {gn_q, wid_q};
  end

  assign out_valid    = (count_q != '0);
  assign out_nonce    = head_q[39:8];
  assign out_work_id  = head_q[7:0];
  assign count        = count_q;
  assign overflow_cnt = ovf_q;
  assign exhausted    = exh_q;

endmodule
